// File: rtl/result_collector_pkg.sv
// -----------------------------------------------------------------------------
// result_collector_pkg
//   Shared definitions for the result collector slice: the FSM state encoding,
//   default data/address widths, the FIFO entry width, and a small helper that
//   clamps a zero map dimension to one.
// -----------------------------------------------------------------------------
package result_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int DATA_W_DEF  = 18;
   localparam int ADDR_W_DEF  = 10;
   localparam int ENTRY_W_DEF = ADDR_W_DEF + DATA_W_DEF;

   // A zero-sized map dimension is treated as a single row/column.
   function automatic logic [7:0] dim_clamp(input logic [7:0] dim);
      return (dim == 8'd0) ? 8'd1 : dim;
   endfunction

endpackage

// File: rtl/result_collector_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
//   Parameterised synchronous FIFO with a registered head: an entry pushed into
//   an empty FIFO is visible on rd_data the following cycle.
//
//   Ports:
//     clk, rst      clock, asynchronous active-high reset (flushes the FIFO)
//     push, wr_data write request and entry; accepted when not full, or when
//                   full with a pop in the same cycle
//     pop           read request; ignored when empty
//     rd_data       head entry (zero while empty)
//     count         number of stored entries (0..DEPTH)
//     full, empty   status flags derived from count
// -----------------------------------------------------------------------------
module result_fifo
   import result_collector_pkg::*;
#(
   parameter  int WIDTH = ENTRY_W_DEF,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [WIDTH-1:0] entry_q [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign pop_ok  = pop && !empty;
   // A full FIFO can still take a write when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);

   // One storage register per entry, written only when the write pointer
   // selects it.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            entry_reg <= '0;
         end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
            entry_reg <= wr_data;
         end
      end

      assign entry_q[gi] = entry_reg;
   end

   assign rd_data = empty ? '0 : entry_q[rd_ptr_reg];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/result_collector.sv
// -----------------------------------------------------------------------------
// result_collector
//   Consumes the allocator's result stream, walks the output map in raster
//   order, tags each result with its output address and queues {addr,data} in
//   a small FIFO toward a ready/valid port. Loads the next convolution centre
//   into the allocator once each non-final result lands, and throttles
//   upstream issue (collector_block) when the FIFO is nearly full.
//
//   Build option: define RELU_EN to clamp negative results to zero before
//   they are queued; otherwise data passes unmodified.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     start                    frame start pulse (honoured only when idle)
//     out_width, out_height    map dimensions, sampled on start (0 -> 1)
//     base_addr                first output address, sampled on start
//     result_ready/_data       allocator result strobe and signed value
//     center_x/y_input         next centre coordinates to the allocator
//     center_write_enable      one-cycle centre load pulse
//     collector_block          FIFO count >= FIFO_DEPTH-1
//     out_valid/data/addr      FIFO head; popped when out_ready is high
//     busy                     frame in progress (RUN or DRAIN)
//     frame_done               one-cycle pulse when the frame has fully drained
//     overflow_err             sticky; set by dropped or stray results
// -----------------------------------------------------------------------------
module result_collector
   import result_collector_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        out_width,
   input  logic [7:0]        out_height,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              result_ready,
   input  logic [DATA_W-1:0] result_data,
   output logic [7:0]        center_x_input,
   output logic [7:0]        center_y_input,
   output logic              center_write_enable,
   output logic              collector_block,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              out_ready,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow_err
);

   localparam int ENTRY_W = ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

   state_t            state_reg;
   state_t            state_next;
   logic [7:0]        width_reg;
   logic [7:0]        height_reg;
   logic [7:0]        x_reg;
   logic [7:0]        y_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [7:0]        cx_reg;
   logic [7:0]        cy_reg;
   logic              cwe_reg;
   logic              frame_done_reg;
   logic              ovf_reg;

   logic              load_frame;
   logic              push_req;
   logic              set_ovf;
   logic              done_next;
   logic              last_pixel;
   logic              row_end;
   logic              accept_ok;

   logic [DATA_W-1:0]  data_in;
   logic [ENTRY_W-1:0] fifo_rd;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;

`ifdef RELU_EN
   assign data_in = result_data[DATA_W-1] ? '0 : result_data;
`else
   assign data_in = result_data;
`endif

   assign row_end    = (x_reg == width_reg - 8'd1);
   assign last_pixel = row_end && (y_reg == height_reg - 8'd1);
   assign fifo_pop   = out_valid && out_ready;
   assign accept_ok  = !fifo_full || fifo_pop;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      load_frame = 1'b0;
      push_req   = 1'b0;
      set_ovf    = 1'b0;
      done_next  = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (start) begin
               load_frame = 1'b1;
               state_next = ST_RUN;
            end
            if (result_ready) begin
               set_ovf = 1'b1;
            end
         end
         ST_RUN: begin
            if (result_ready) begin
               if (accept_ok) begin
                  push_req = 1'b1;
                  if (last_pixel) begin
                     state_next = ST_DRAIN;
                  end
               end else begin
                  set_ovf = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (result_ready) begin
               set_ovf = 1'b1;
            end
            if (fifo_empty) begin
               done_next  = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------- raster counters and centre
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width_reg      <= '0;
         height_reg     <= '0;
         x_reg          <= '0;
         y_reg          <= '0;
         addr_reg       <= '0;
         cx_reg         <= '0;
         cy_reg         <= '0;
         cwe_reg        <= 1'b0;
         frame_done_reg <= 1'b0;
         ovf_reg        <= 1'b0;
      end else begin
         cwe_reg        <= 1'b0;
         frame_done_reg <= done_next;

         if (load_frame) begin
            width_reg  <= dim_clamp(out_width);
            height_reg <= dim_clamp(out_height);
            x_reg      <= '0;
            y_reg      <= '0;
            addr_reg   <= base_addr;
            cx_reg     <= '0;
            cy_reg     <= '0;
            cwe_reg    <= 1'b1;
         end else if (push_req) begin
            addr_reg <= addr_reg + ADDR_W'(1);
            if (last_pixel) begin
               // Frame complete: no further centre to load.
               x_reg <= '0;
               y_reg <= '0;
            end else if (row_end) begin
               x_reg   <= '0;
               y_reg   <= y_reg + 8'd1;
               cx_reg  <= '0;
               cy_reg  <= y_reg + 8'd1;
               cwe_reg <= 1'b1;
            end else begin
               x_reg   <= x_reg + 8'd1;
               cx_reg  <= x_reg + 8'd1;
               cy_reg  <= y_reg;
               cwe_reg <= 1'b1;
            end
         end

         // A stray result in the same cycle as start still flags the error.
         if (set_ovf) begin
            ovf_reg <= 1'b1;
         end else if (load_frame) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_req),
      .pop     (fifo_pop),
      .wr_data ({addr_reg, data_in}),
      .rd_data (fifo_rd),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_valid           = !fifo_empty;
   assign out_addr            = fifo_rd[ENTRY_W-1:DATA_W];
   assign out_data            = fifo_rd[DATA_W-1:0];
   assign collector_block     = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
   assign busy                = (state_reg != ST_IDLE);
   assign frame_done          = frame_done_reg;
   assign overflow_err        = ovf_reg;
   assign center_x_input      = cx_reg;
   assign center_y_input      = cy_reg;
   assign center_write_enable = cwe_reg;

endmodule

// File: tb/tb_result_collector.sv
`timescale 1ns/1ps
module tb_result_collector;

   localparam int DATA_W = 18;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [7:0]        out_width;
   logic [7:0]        out_height;
   logic [ADDR_W-1:0] base_addr;
   logic              result_ready;
   logic [DATA_W-1:0] result_data;
   logic [7:0]        center_x_input;
   logic [7:0]        center_y_input;
   logic              center_write_enable;
   logic              collector_block;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_ready;
   logic              busy;
   logic              frame_done;
   logic              overflow_err;

   always #5 clk = ~clk;

   result_collector #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .out_width           (out_width),
      .out_height          (out_height),
      .base_addr           (base_addr),
      .result_ready        (result_ready),
      .result_data         (result_data),
      .center_x_input      (center_x_input),
      .center_y_input      (center_y_input),
      .center_write_enable (center_write_enable),
      .collector_block     (collector_block),
      .out_valid           (out_valid),
      .out_data            (out_data),
      .out_addr            (out_addr),
      .out_ready           (out_ready),
      .busy                (busy),
      .frame_done          (frame_done),
      .overflow_err        (overflow_err)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // ------------------------------------------------------ reference model
   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t exp_q[$];
   int   m_state = 0;        // 0 idle, 1 collecting, 2 draining
   int   m_w, m_h, m_idx;
   logic [ADDR_W-1:0] m_base;
   bit   m_ovf    = 1'b0;
   bit   cwe_exp  = 1'b0;
   bit   done_exp = 1'b0;
   int   cx_exp, cy_exp;
   int   obs_pops  = 0;
   int   obs_cwes  = 0;
   int   obs_dones = 0;

   function automatic logic [DATA_W-1:0] relu_m(input logic [DATA_W-1:0] d);
`ifdef RELU_EN
      return d[DATA_W-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   // Each falling edge: check outputs against the model, then predict what
   // the next rising edge does with the inputs now on the pins.
   always @(negedge clk) begin
      int   cur;
      int   sz;
      bit   pop_now;
      bit   n_cwe;
      bit   n_done;
      ent_t e;
      if (rst) begin
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_frame_done", frame_done, 1'b0);
         chk("rst_ovf", overflow_err, 1'b0);
         chk("rst_cwe", center_write_enable, 1'b0);
         chk("rst_block", collector_block, 1'b0);
         exp_q.delete();
         m_state  = 0;
         m_ovf    = 1'b0;
         cwe_exp  = 1'b0;
         done_exp = 1'b0;
      end else begin
         cur = m_state;
         sz  = exp_q.size();
         chk("busy", busy, (cur != 0));
         chk("frame_done", frame_done, done_exp);
         chk("cwe", center_write_enable, cwe_exp);
         if (cwe_exp) begin
            chk("centre_x", center_x_input, 8'(cx_exp));
            chk("centre_y", center_y_input, 8'(cy_exp));
         end
         chk("ovf", overflow_err, m_ovf);
         chk("out_valid", out_valid, (sz > 0));
         chk("block", collector_block, (sz >= DEPTH - 1));
         if (sz > 0) begin
            chk("head_addr", out_addr, exp_q[0].a);
            chk("head_data", out_data, exp_q[0].d);
         end
         if (frame_done) obs_dones++;
         if (center_write_enable) obs_cwes++;
         if (out_valid && out_ready) obs_pops++;

         n_cwe   = 1'b0;
         n_done  = 1'b0;
         pop_now = (sz > 0) && out_ready;
         if (pop_now) void'(exp_q.pop_front());
         case (cur)
            0: begin
               if (start) begin
                  m_state = 1;
                  m_w     = (out_width == 8'd0) ? 1 : int'(out_width);
                  m_h     = (out_height == 8'd0) ? 1 : int'(out_height);
                  m_base  = base_addr;
                  m_idx   = 0;
                  m_ovf   = 1'b0;
                  n_cwe   = 1'b1;
                  cx_exp  = 0;
                  cy_exp  = 0;
               end
               if (result_ready) m_ovf = 1'b1;
            end
            1: begin
               if (result_ready) begin
                  if (sz < DEPTH || pop_now) begin
                     e.a = ADDR_W'(int'(m_base) + m_idx);
                     e.d = relu_m(result_data);
                     exp_q.push_back(e);
                     m_idx++;
                     if (m_idx == m_w * m_h) begin
                        m_state = 2;
                     end else begin
                        n_cwe  = 1'b1;
                        cx_exp = m_idx % m_w;
                        cy_exp = m_idx / m_w;
                     end
                  end else begin
                     m_ovf = 1'b1;
                  end
               end
            end
            default: begin
               if (result_ready) m_ovf = 1'b1;
               if (sz == 0) begin
                  n_done  = 1'b1;
                  m_state = 0;
               end
            end
         endcase
         cwe_exp  = n_cwe;
         done_exp = n_done;
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int w, input int h, input int b);
      out_width  = 8'(w);
      out_height = 8'(h);
      base_addr  = ADDR_W'(b);
      start      = 1'b1;
      tick();
      start      = 1'b0;
      $display("start w=%0d h=%0d base=%0h", w, h, b);
   endtask

   task automatic send(input logic [DATA_W-1:0] d);
      result_ready = 1'b1;
      result_data  = d;
      tick();
      result_ready = 1'b0;
      $display("result data=%0h out_ready=%0b", d, out_ready);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((m_state != 0 || busy) && n < 400) begin
         tick();
         n++;
      end
      chk(tag, (n < 400), 1'b1);
      tick();
      tick();
      $display("frame idle after %0d cycles", n);
   endtask

   // ------------------------------------------------------------ stimulus
   logic [DATA_W-1:0] basic_vals [4];
   int p0, c0, f0, n;

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      out_width    = '0;
      out_height   = '0;
      base_addr    = '0;
      result_ready = 1'b0;
      result_data  = '0;
      out_ready    = 1'b0;
      tick();
      chk("reset_valid", out_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_data", out_data, 18'h0);
      chk("reset_addr", out_addr, 10'h0);
      chk("reset_cx", center_x_input, 8'h0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Basic 2x2 frame.
      basic_vals[0] = 18'd5;
      basic_vals[1] = 18'h3FFFD;
      basic_vals[2] = 18'd7;
      basic_vals[3] = 18'd9;
      out_ready = 1'b1;
      p0 = obs_pops; c0 = obs_cwes; f0 = obs_dones;
      do_start(2, 2, 'h010);
      for (int i = 0; i < 4; i++) begin
         repeat (3) tick();
         send(basic_vals[i]);
         chk("basic_addr", out_addr, ADDR_W'(16 + i));
         if (i == 1) begin
`ifdef RELU_EN
            chk("relu_neg", out_data, 18'h0);
`else
            chk("pass_neg", out_data, 18'h3FFFD);
`endif
         end
      end
      wait_idle("basic_done");
      chk("basic_pops", obs_pops - p0, 4);
      chk("basic_cwes", obs_cwes - c0, 4);
      chk("basic_dones", obs_dones - f0, 1);

      // Backpressure on a 5x1 frame.
      out_ready = 1'b0;
      do_start(5, 1, $urandom_range(0, 1023));
      for (int i = 0; i < 3; i++) begin
         send(DATA_W'($urandom));
         tick();
      end
      chk("bp_block3", collector_block, 1'b1);
      send(DATA_W'($urandom));
      chk("bp_fourth_ok", overflow_err, 1'b0);
      send(DATA_W'($urandom));
      chk("bp_fifth_ovf", overflow_err, 1'b1);
      p0 = obs_pops;
      out_ready = 1'b1;
      repeat (6) tick();
      chk("bp_pops", obs_pops - p0, 4);
      send(DATA_W'($urandom));
      wait_idle("bp_done");

      // Full FIFO with a simultaneous pop and push.
      out_ready = 1'b0;
      p0 = obs_pops;
      do_start(6, 1, $urandom_range(0, 1023));
      for (int i = 0; i < 4; i++) send(DATA_W'($urandom));
      chk("full_block", collector_block, 1'b1);
      out_ready = 1'b1;
      send(DATA_W'($urandom));
      chk("full_pop_ovf", overflow_err, 1'b0);
      chk("full_pop_block", collector_block, 1'b1);
      send(DATA_W'($urandom));
      wait_idle("full_done");
      chk("full_pops", obs_pops - p0, 6);
      chk("full_ovf_end", overflow_err, 1'b0);

      // Address wrap.
      out_ready = 1'b1;
      do_start(4, 1, 'h3FE);
      for (int i = 0; i < 4; i++) begin
         send(DATA_W'($urandom));
         if (i == 0) chk("wrap_first", out_addr, 10'h3FE);
         if (i == 2) chk("wrap_zero", out_addr, 10'h000);
         tick();
      end
      wait_idle("wrap_done");

      // Randomised frames with random gaps and backpressure.
      f0 = obs_dones;
      for (int f = 0; f < 12; f++) begin
         do_start($urandom_range(0, 4), $urandom_range(1, 3), $urandom_range(0, 1023));
         n = 0;
         while (m_state == 1 && n < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
               result_ready = 1'b1;
               result_data  = DATA_W'($urandom);
            end else begin
               result_ready = 1'b0;
            end
            tick();
            n++;
         end
         result_ready = 1'b0;
         chk("rnd_collect_bound", (n < 300), 1'b1);
         wait_idle("rnd_done");
      end
      chk("rnd_dones", obs_dones - f0, 12);

      // Stray result while idle.
      do_start(1, 1, 'h100);
      send(18'd1);
      wait_idle("stray_prep");
      chk("stray_pre_ovf", overflow_err, 1'b0);
      send(18'd42);
      chk("stray_ovf", overflow_err, 1'b1);
      chk("stray_no_out", out_valid, 1'b0);
      tick();
      chk("stray_no_out2", out_valid, 1'b0);

      // Asynchronous reset mid-frame with two entries queued.
      out_ready = 1'b0;
      do_start(4, 2, 'h020);
      send(18'd11);
      send(18'd12);
      chk("midrst_queued", out_valid, 1'b1);
      f0 = obs_dones;
      rst = 1'b1;
      #1;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("midrst_no_done", obs_dones - f0, 0);
      chk("midrst_idle", busy, 1'b0);

      // Recovery frame after reset.
      do_start(2, 1, 'h055);
      send(18'd3);
      tick();
      send(18'd4);
      wait_idle("recover_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Sits directly downstream of the allocator and consumes its `result_ready`/`result_data` stream.
- Walks the output feature map in raster order, tags each result with its output address, and buffers it in a small FIFO toward a ready/valid output port.
- Drives the allocator's `center_x_input`/`center_y_input`/`center_write_enable` so the next convolution centre is loaded once the previous result lands.
- Asserts `collector_block` to throttle upstream issue when the FIFO is nearly full.

Parameters:
- DATA_W, 18, result/output data width
- ADDR_W, 10, output address width
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a frame when IDLE, ignored otherwise
- out_width  in  8  output map width, sampled on start (0 treated as 1)
- out_height  in  8  output map height, sampled on start (0 treated as 1)
- base_addr  in  ADDR_W  first output address, sampled on start
- result_ready  in  1  allocator result strobe
- result_data  in  DATA_W  allocator result, signed two's complement
- center_x_input  out  8  next centre x to allocator
- center_y_input  out  8  next centre y to allocator
- center_write_enable  out  1  one-cycle centre load pulse
- collector_block  out  1  high when FIFO count >= FIFO_DEPTH-1
- out_valid  out  1  FIFO head valid
- out_data  out  DATA_W  FIFO head data
- out_addr  out  ADDR_W  FIFO head address
- out_ready  in  1  downstream accept
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse on DRAIN->IDLE
- overflow_err  out  1  sticky; cleared only by rst or start

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, counters 0.
- States:
  - IDLE: on start, latch dimensions and base, set x=y=0, addr=base, clear overflow_err, go RUN. The next cycle drives centre (0,0) with center_write_enable=1.
  - RUN: each accepted result pushes {addr,data}, then addr+=1 (wraps modulo 2^ADDR_W) and x+=1. When x==width-1, x wraps to 0 and y+=1.
    - If the pushed result was not the last pixel, pulse center_write_enable with the new (x,y) the cycle after acceptance.
    - After the last pixel (x==width-1, y==height-1), issue no centre write and go DRAIN.
  - DRAIN: when the FIFO is empty, pulse frame_done and go IDLE.
- FIFO rules:
  - Registered head: a push into an empty FIFO at cycle t gives out_valid at t+1.
  - A pop occurs when out_valid && out_ready.
  - Push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH with a pop in the same cycle.
  - A push rejected when full drops the result without advancing counters and sets overflow_err.
- result_ready in IDLE or DRAIN: ignored, sets overflow_err, no counter change.
- collector_block is combinational from the registered count.
- start while busy: ignored.
- Async rst mid-frame: FIFO flushed, no frame_done.

Optional Feature:
- RELU_EN: when defined, a negative result_data (MSB set) is replaced with 0 before the push; addressing is unchanged.
- Undefined: data passes unmodified.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, RUN=1, DRAIN=2)
  - DATA_W/ADDR_W defaults
  - the FIFO entry width constant (ADDR_W+DATA_W)
- One sub-module, result_fifo: parameterised synchronous FIFO with push/pop/count/full/empty. The raster counters, centre logic and FSM stay in the top.

Test Plan:
- Basic frame:
  - Stimulus: width=2, height=2, base=0x010, out_ready=1; four results 5,-3,7,9, each 4 cycles apart.
  - Response: centre writes (0,0),(1,0),(0,1),(1,1); outputs addr 0x010..0x013 with data 5,-3,7,9; one frame_done pulse; centre write count=4.
- Backpressure:
  - Stimulus: out_ready=0; push 3 results.
  - Response: collector_block=1 after the third; the fourth push is accepted; a fifth sets overflow_err with count staying 4; release out_ready and exactly 4 pops occur in order.
- Full plus simultaneous pop:
  - Stimulus: FIFO full, out_ready=1, result_ready=1 in the same cycle.
  - Response: push accepted, count stays 4, overflow_err stays 0.
- Address wrap:
  - Stimulus: base=0x3FE, width=4, height=1.
  - Response: addresses 0x3FE,0x3FF,0x000,0x001.
- Stray and reset:
  - Stimulus: result_ready in IDLE; separately, rst asserted mid-frame with 2 entries queued.
  - Response: stray result sets overflow_err and emits no output; after rst, out_valid=0, busy=0, no frame_done.
- RELU_EN build:
  - Stimulus: result -3 (0x3FFFD).
  - Response: out_data=0.
  - Same stimulus without RELU_EN: out_data=0x3FFFD.
